// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: registered FSM that sequences fetch, decode,
// execute, memory and write-back steps and drives every datapath select/enable.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_t r_state;
  ctl_t   r_ctl;
  logic   r_illegal;

  state_t w_next;
  logic   w_illegal_dec;
  logic   w_pc_write;

  // Moore decode of a state; loaded together with the state so outputs are registered.
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_EXECUTE:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:      begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:    begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDI_WB:   c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next        = r_state;
    w_illegal_dec = 1'b0;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      w_next = S_EXECUTE;
          OP_LW, OP_SW:  w_next = S_MEM_ADDR;
          OP_BEQ:        w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI:       w_next = S_ADDI_EXEC;
          default: begin
            w_next        = S_FETCH;
            w_illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECUTE:   w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ctl     <= decode_ctl(S_FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctl   <= decode_ctl(w_next);
      if (w_illegal_dec) r_illegal <= 1'b1;
    end
  end

  // FETCH loads IR and PC in the cycle memory delivers the word (Mealy terms).
  assign w_pc_write = r_ctl.pc_write | ((r_state == S_FETCH) & mem_ready);

  assign pc_en      = rst_n & (w_pc_write | (r_ctl.pc_write_cond & zero));
  assign ir_write   = rst_n & (r_state == S_FETCH) & mem_ready;
  assign i_or_d     = rst_n & r_ctl.i_or_d;
  assign mem_read   = rst_n & r_ctl.mem_read;
  assign mem_write  = rst_n & r_ctl.mem_write;
  assign reg_dst    = rst_n & r_ctl.reg_dst;
  assign mem_to_reg = rst_n & r_ctl.mem_to_reg;
  assign reg_write  = rst_n & r_ctl.reg_write;
  assign alu_src_a  = rst_n & r_ctl.alu_src_a;
  assign alu_src_b  = rst_n ? r_ctl.alu_src_b : 2'b00;
  assign alu_op     = rst_n ? r_ctl.alu_op    : 2'b00;
  assign pc_source  = rst_n ? r_ctl.pc_source : 2'b00;
  assign state      = rst_n ? r_state         : 4'd0;
  assign illegal_op = rst_n & r_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: one cycle-by-cycle vector table covering every
// state, stalls, reset abort and the sticky illegal flag, plus CPI sequences.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .state      (state),
    .illegal_op (illegal_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // Expected vector layout:
  // {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int rst, input int op, input int z, input int rdy,
                              input int st, input int pcen, input int iord, input int mr,
                              input int mw, input int irw, input int rd, input int m2r,
                              input int rw, input int asa, input int asb, input int aop,
                              input int psrc, input int ill);
    vec_t v;
    v.rst = 1'(rst);
    v.op  = 6'(op);
    v.z   = 1'(z);
    v.rdy = 1'(rdy);
    v.exp = {4'(st), 1'(pcen), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rd), 1'(m2r),
             1'(rw), 1'(asa), 2'(asb), 2'(aop), 2'(psrc), 1'(ill)};
    return v;
  endfunction

  function automatic logic [19:0] actual();
    return {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  // Runs one instruction starting in FETCH with mem_ready=1 and counts its cycles.
  task automatic run_instr(input string name, input logic [5:0] op, input int exp_cyc,
                           input int exp_mw, input int exp_rw_rt);
    int cyc;
    int mw;
    int rw_rt;
    cyc = 0; mw = 0; rw_rt = 0;
    opcode = op; mem_ready = 1'b1; zero = 1'b0;
    do begin
      if (mem_write) mw++;
      if (reg_write && !reg_dst) rw_rt++;
      cyc++;
      @(negedge clk); #1;
    end while (state != 4'd0 && cyc < 20);
    check_int({name, "_cycles"}, cyc, exp_cyc);
    check_int({name, "_mem_write_pulses"}, mw, exp_mw);
    check_int({name, "_reg_write_rt"}, rw_rt, exp_rw_rt);
  endtask

  initial begin
    int synced;
    rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;

    //            rst op    z rdy st pce iod mr mw irw rd m2r rw asa asb aop psr ill
    // reset, then R-type
    vq.push_back(mk(0, 'h00, 0, 1,  0,  0,  0, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(0, 'h00, 0, 1,  0,  0,  0, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(1, 'h00, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h00, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h00, 0, 1,  6,  0,  0, 0, 0, 0,  0, 0,  0, 1,  0,  2,  0,  0));
    vq.push_back(mk(1, 'h00, 0, 1,  7,  0,  0, 0, 0, 0,  1, 0,  1, 0,  0,  0,  0,  0));
    // lw with three stall cycles in MEM_READ
    vq.push_back(mk(1, 'h23, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 1,  2,  0,  0, 0, 0, 0,  0, 0,  0, 1,  2,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 0,  3,  0,  1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 0,  3,  0,  1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 0,  3,  0,  1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 1,  3,  0,  1, 1, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(1, 'h23, 0, 1,  4,  0,  0, 0, 0, 0,  0, 1,  1, 0,  0,  0,  0,  0));
    // beq taken, then not taken
    vq.push_back(mk(1, 'h04, 1, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h04, 1, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h04, 1, 1,  8,  1,  0, 0, 0, 0,  0, 0,  0, 1,  0,  1,  1,  0));
    vq.push_back(mk(1, 'h04, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h04, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h04, 0, 1,  8,  0,  0, 0, 0, 0,  0, 0,  0, 1,  0,  1,  1,  0));
    // FETCH stall, then j
    vq.push_back(mk(1, 'h02, 0, 0,  0,  0,  0, 1, 0, 0,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h02, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h02, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h02, 0, 1,  9,  1,  0, 0, 0, 0,  0, 0,  0, 0,  0,  0,  2,  0));
    // sw
    vq.push_back(mk(1, 'h2B, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h2B, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h2B, 0, 1,  2,  0,  0, 0, 0, 0,  0, 0,  0, 1,  2,  0,  0,  0));
    vq.push_back(mk(1, 'h2B, 0, 1,  5,  0,  1, 0, 1, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    // addi
    vq.push_back(mk(1, 'h08, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h08, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h08, 0, 1, 10,  0,  0, 0, 0, 0,  0, 0,  0, 1,  2,  0,  0,  0));
    vq.push_back(mk(1, 'h08, 0, 1, 11,  0,  0, 0, 0, 0,  0, 0,  1, 0,  0,  0,  0,  0));
    // illegal opcode, flag stays set through an R-type
    vq.push_back(mk(1, 'h3F, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h3F, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));
    vq.push_back(mk(1, 'h00, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  1));
    vq.push_back(mk(1, 'h00, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  1));
    vq.push_back(mk(1, 'h00, 0, 1,  6,  0,  0, 0, 0, 0,  0, 0,  0, 1,  0,  2,  0,  1));
    vq.push_back(mk(1, 'h00, 0, 1,  7,  0,  0, 0, 0, 0,  1, 0,  1, 0,  0,  0,  0,  1));
    // sw aborted by reset while stalled in MEM_WRITE
    vq.push_back(mk(1, 'h2B, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  1));
    vq.push_back(mk(1, 'h2B, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  1));
    vq.push_back(mk(1, 'h2B, 0, 1,  2,  0,  0, 0, 0, 0,  0, 0,  0, 1,  2,  0,  0,  1));
    vq.push_back(mk(1, 'h2B, 0, 0,  5,  0,  1, 0, 1, 0,  0, 0,  0, 0,  0,  0,  0,  1));
    vq.push_back(mk(0, 'h2B, 0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(0, 'h2B, 1, 1,  0,  0,  0, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0));
    vq.push_back(mk(1, 'h2B, 0, 1,  0,  1,  0, 1, 0, 1,  0, 0,  0, 0,  1,  0,  0,  0));
    vq.push_back(mk(1, 'h2B, 0, 1,  1,  0,  0, 0, 0, 0,  0, 0,  0, 0,  3,  0,  0,  0));

    // driver: inputs change on the falling edge, outputs compared 1 time unit later
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst; opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].rdy;
      #1;
      n_checks++;
      if (actual() !== vq[i].exp) begin
        n_errors++;
        $display("FAIL vec%0d: act=%05h req=%05h (state act=%0d req=%0d)",
                 i, actual(), vq[i].exp, state, vq[i].exp[19:16]);
      end
      if (mem_read && mem_write) begin
        n_errors++;
        $display("FAIL rw_exclusive vec%0d: act=both req=one", i);
      end
    end

    // finish the in-flight sw, then run j, sw, addi back to back
    synced = 0;
    for (int k = 0; k < 20 && synced == 0; k++) begin
      @(negedge clk); #1;
      if (state == 4'd0) synced = 1;
    end
    check_int("sync_to_fetch", synced, 1);
    run_instr("j",    6'h02, 3, 0, 0);
    run_instr("sw",   6'h2B, 4, 1, 0);
    run_instr("addi", 6'h08, 4, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle MIPS control unit. It sequences the shared datapath (PC, memory, IR, register file, ALU and the 2:1/4:1 operand and write-back muxes) through fetch, decode, execute, memory and write-back steps. It drives every mux select and every write enable from a registered state machine. It stalls on a memory ready handshake and flags unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- opcode  in  6  IR[31:26]; stable outside FETCH because the IR loads only in FETCH.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC load enable, equal to pc_write | (pc_write_cond & zero).
- i_or_d  out  1  address mux select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  write-register mux select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data mux select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A mux select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B mux select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct field.
- pc_source  out  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code, for debug.
- illegal_op  out  1  sticky flag: an unsupported opcode was decoded.

## Operation
- States and codes:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXECUTE = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11
- Every output not listed for a state is 0.
- Per-state outputs:
  - FETCH: mem_read=1, alu_src_b=01. ir_write and pc_write equal mem_ready (Mealy terms). Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_b=11. Next state by opcode:
    - 0x00 → EXECUTE
    - 0x23 or 0x2B → MEM_ADDR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - 0x08 → ADDI_EXEC
    - any other opcode → FETCH, and illegal_op is set.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_READ if opcode=0x23, otherwise to MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1. Goes to FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH.
  - EXECUTE: alu_src_a=1, alu_op=10. Goes to R_WB.
  - R_WB: reg_dst=1, reg_write=1. Goes to FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
  - JUMP: pc_write=1, pc_source=10. Goes to FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10. Goes to ADDI_WB.
  - ADDI_WB: reg_write=1. Goes to FETCH.
- pc_write and pc_write_cond are internal signals. Only pc_en leaves the block.
- illegal_op stays set until reset. Execution continues after it is set.
- mem_read and mem_write are never high in the same cycle.

## Timing
- Reset:
  - While rst_n=0 at a rising edge, the state register loads FETCH and illegal_op clears.
  - While rst_n is low, all outputs are forced to 0, including state=0 and pc_en=0.
  - The first fetch request appears in the first cycle with rst_n=1.
- Reset asserted mid-instruction aborts the instruction at the next edge. No write enable is asserted in the cycle that follows.
- Next-state logic and Moore outputs are registered-state decodes. ir_write, pc_write and pc_en depend combinationally on mem_ready and zero in the same cycle.
- Cycles per instruction with mem_ready held at 1:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
  - illegal opcode: 2
- Each extra cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes stay asserted and addresses stay stable throughout the stall.

## Test plan
- Reset, then rst_n=1 with mem_ready=1 and opcode=0x00: state sequence 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7. pc_en=1 only in the FETCH cycles.
- lw (opcode 0x23) with mem_ready held 0 for 3 cycles in MEM_READ: state sequence 0,1,2,3,3,3,3,4,0. mem_read=1 and i_or_d=1 for all four MEM_READ cycles.
- beq (opcode 0x04): with zero=1, pc_en=1 and pc_source=01 in state 8; with zero=0, pc_en=0 in state 8.
- j, then sw, then addi back to back with mem_ready=1: cycle counts 3, 4 and 4. The sw asserts mem_write exactly once; the addi asserts reg_write with reg_dst=0.
- opcode=0x3F: state sequence 0,1,0. illegal_op goes to 1 after the DECODE edge and stays 1 through following instructions until rst_n=0.
- rst_n pulled low during MEM_WRITE with mem_ready=0: all outputs are 0 while rst_n is low, and after release the state restarts at FETCH.
